// File: rtl/z88_pkg.sv
// Shared types and widths for the Z88 slot-0 SRAM arbiter.
package z88_pkg;

  localparam int Z88_ADDR_W = 19;
  localparam int Z88_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } arbState_e;

  typedef enum logic {
    CPU,
    LCD
  } owner_e;

endpackage

// File: rtl/z88_sram_arb.sv
// Z88 internal SRAM arbiter: serialises CPU and LCD-fetch accesses into fixed SRAM cycles.
// Optional LCD starvation guard enabled by defining Z88_SRAM_ARB_STARVE_GUARD_EN.
module z88_sram_arb
  import z88_pkg::*;
#(
  parameter int ACCESS_CYC = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [Z88_ADDR_W-1:0] cpu_addr,
  input  logic [Z88_DATA_W-1:0] cpu_wdata,
  output logic [Z88_DATA_W-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  lcd_req,
  input  logic [Z88_ADDR_W-1:0] lcd_addr,
  output logic [Z88_DATA_W-1:0] lcd_rdata,
  output logic                  lcd_ack,
  output logic [Z88_ADDR_W-1:0] ram_a,
  output logic [Z88_DATA_W-1:0] ram_di,
  input  logic [Z88_DATA_W-1:0] ram_do,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  localparam int CNT_W = $clog2(ACCESS_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(ACCESS_CYC - 2);

  if (ACCESS_CYC < 3 || STARVE_MAX < 1) begin : gBadParam
    $error("z88_sram_arb: ACCESS_CYC must be >= 3 and STARVE_MAX >= 1");
  end

  arbState_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  owner_e                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [Z88_ADDR_W-1:0] addr_q, addr_d;
  logic [Z88_DATA_W-1:0] di_q, di_d;
  logic [Z88_DATA_W-1:0] cpuRdata_q, cpuRdata_d;
  logic [Z88_DATA_W-1:0] lcdRdata_q, lcdRdata_d;
  logic                  ceN_q, ceN_d, oeN_q, oeN_d, weN_q, weN_d;
  logic                  cpuAck_q, cpuAck_d, lcdAck_q, lcdAck_d;
  logic                  grantLcd;
  logic                  inAcc;

`ifdef Z88_SRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;
  logic          cpuGrant;

  assign grantLcd = lcd_req && (!cpu_req || (starve_q == SW'(STARVE_MAX)));
  assign cpuGrant = (state_q == IDLE) && cpu_req && !grantLcd;

  // Counts CPU wins while the LCD is waiting; any idle LCD cycle forgives the debt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!lcd_req) begin
      starve_q <= '0;
    end else if ((state_q == IDLE) && grantLcd) begin
      starve_q <= '0;
    end else if (cpuGrant && (starve_q != SW'(STARVE_MAX))) begin
      starve_q <= starve_q + SW'(1);
    end
  end
`else
  assign grantLcd = lcd_req && !cpu_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    di_d       = di_q;
    cpuRdata_d = cpuRdata_q;
    lcdRdata_d = lcdRdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req || lcd_req) begin
          state_d = ACC;
          cnt_d   = '0;
          if (grantLcd) begin
            owner_d = LCD;
            we_d    = 1'b0;
            addr_d  = lcd_addr;
          end else begin
            owner_d = CPU;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            di_d    = cpu_wdata;
          end
        end
      end
      ACC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == CPU) cpuRdata_d = ram_do;
            else                lcdRdata_d = ram_do;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and acks are decoded from the next state so every output leaves a flop.
    inAcc    = (state_d == ACC);
    ceN_d    = !inAcc;
    oeN_d    = !(inAcc && !we_d);
    weN_d    = !(inAcc && we_d && (cnt_d >= CNT_W'(1)) && (cnt_d <= WE_LAST));
    cpuAck_d = (state_d == DONE) && (owner_d == CPU);
    lcdAck_d = (state_d == DONE) && (owner_d == LCD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      di_q       <= '0;
      cpuRdata_q <= '0;
      lcdRdata_q <= '0;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
      cpuAck_q   <= 1'b0;
      lcdAck_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      di_q       <= di_d;
      cpuRdata_q <= cpuRdata_d;
      lcdRdata_q <= lcdRdata_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
      cpuAck_q   <= cpuAck_d;
      lcdAck_q   <= lcdAck_d;
    end
  end

  assign ram_a     = addr_q;
  assign ram_di    = di_q;
  assign ram_ce_n  = ceN_q;
  assign ram_oe_n  = oeN_q;
  assign ram_we_n  = weN_q;
  assign cpu_rdata = cpuRdata_q;
  assign lcd_rdata = lcdRdata_q;
  assign cpu_ack   = cpuAck_q;
  assign lcd_ack   = lcdAck_q;

endmodule

// File: tb/tb_z88_sram_arb.sv
// Directed self-checking bench for z88_sram_arb with a behavioural 512 KB SRAM.
// Starvation expectations follow Z88_SRAM_ARB_STARVE_GUARD_EN.
module tb_z88_sram_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpuReq = 1'b0, cpuWe = 1'b0;
  logic [18:0] cpuAddr = '0;
  logic [7:0]  cpuWdata = '0;
  logic [7:0]  cpuRdata;
  logic        cpuAck;
  logic        lcdReq = 1'b0;
  logic [18:0] lcdAddr = '0;
  logic [7:0]  lcdRdata;
  logic        lcdAck;
  logic [18:0] ramA;
  logic [7:0]  ramDi, ramDo;
  logic        ramCeN, ramOeN, ramWeN;

  logic [7:0]  mem [0:(1<<19)-1];

  int assertCount = 0;
  int failCount   = 0;

  z88_sram_arb #(.ACCESS_CYC(3), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpuReq),
    .cpu_we   (cpuWe),
    .cpu_addr (cpuAddr),
    .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata),
    .cpu_ack  (cpuAck),
    .lcd_req  (lcdReq),
    .lcd_addr (lcdAddr),
    .lcd_rdata(lcdRdata),
    .lcd_ack  (lcdAck),
    .ram_a    (ramA),
    .ram_di   (ramDi),
    .ram_do   (ramDo),
    .ram_ce_n (ramCeN),
    .ram_oe_n (ramOeN),
    .ram_we_n (ramWeN)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: write commits on a clock edge while CE and WE are both low.
  always @(posedge clk) begin
    if (!ramCeN && !ramWeN) mem[ramA] <= ramDi;
  end
  assign ramDo = mem[ramA];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [18:0] cA,
                               input logic [7:0] cD, input logic lReq, input logic [18:0] lA);
    cpuReq = cReq; cpuWe = cWe; cpuAddr = cA; cpuWdata = cD;
    lcdReq = lReq; lcdAddr = lA;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ceLow, oeLow, ackAt, lcdAt, goodBus, cpuAcks, cpuBefore, anyAck;
    logic [2:0] weBits;

    mem[19'h12345] <= 8'hA5;
    mem[19'h00123] <= 8'hC3;
    mem[19'h40000] <= 8'h5A;
    mem[19'h00200] <= 8'h11;
    mem[19'h00010] <= 8'h00;
    mem[19'h00020] <= 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("rst_ce", ramCeN, 1);
    checkOutput("rst_oe", ramOeN, 1);
    checkOutput("rst_we", ramWeN, 1);
    checkOutput("rst_acks", {cpuAck, lcdAck}, 0);
    checkOutput("rst_ram_a", ramA, 0);
    checkOutput("rst_rdata", {cpuRdata, lcdRdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Lone CPU read
    applyStimulus(1'b1, 1'b0, 19'h12345, 8'h00, 1'b0, 19'h0);
    ceLow = 0; oeLow = 0; ackAt = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!ramCeN) ceLow++;
      if (!ramOeN) oeLow++;
      if (cpuAck && ackAt < 0) begin ackAt = i; cpuReq = 1'b0; end
    end
    checkOutput("rd_ce_cycles", ceLow, 3);
    checkOutput("rd_oe_cycles", oeLow, 3);
    checkOutput("rd_ack_latency", ackAt, 4);
    checkOutput("rd_data", cpuRdata, 8'hA5);

    // CPU write
    applyStimulus(1'b1, 1'b1, 19'h00010, 8'h3C, 1'b0, 19'h0);
    weBits = 3'b000; goodBus = 0; oeLow = 0; ackAt = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 3) begin
        weBits[3-i] = ramWeN;
        if (!ramCeN && ramA == 19'h00010 && ramDi == 8'h3C) goodBus++;
      end
      if (!ramOeN) oeLow++;
      if (cpuAck && ackAt < 0) begin ackAt = i; cpuReq = 1'b0; end
    end
    checkOutput("wr_we_pattern", weBits, 3'b101);
    checkOutput("wr_bus_stable", goodBus, 3);
    checkOutput("wr_oe_never_low", oeLow, 0);
    checkOutput("wr_ack_latency", ackAt, 4);
    checkOutput("wr_mem", mem[19'h00010], 8'h3C);

    // Simultaneous CPU and LCD requests
    applyStimulus(1'b1, 1'b0, 19'h00123, 8'h00, 1'b1, 19'h40000);
    ackAt = -1; lcdAt = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpuAck && ackAt < 0) begin ackAt = i; cpuReq = 1'b0; end
      if (lcdAck && lcdAt < 0) begin lcdAt = i; lcdReq = 1'b0; end
    end
    checkOutput("sim_cpu_ack", ackAt, 4);
    checkOutput("sim_lcd_ack", lcdAt, 9);
    checkOutput("sim_cpu_data", cpuRdata, 8'hC3);
    checkOutput("sim_lcd_data", lcdRdata, 8'h5A);

    // Continuous CPU demand with LCD waiting
    applyStimulus(1'b1, 1'b0, 19'h00200, 8'h00, 1'b1, 19'h40000);
    cpuAcks = 0; cpuBefore = -1; lcdAt = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (cpuAck) cpuAcks++;
      if (lcdAck && lcdAt < 0) begin lcdAt = i; cpuBefore = cpuAcks; lcdReq = 1'b0; end
    end
    cpuReq = 1'b0; lcdReq = 1'b0;
    repeat (8) @(negedge clk);
`ifdef Z88_SRAM_ARB_STARVE_GUARD_EN
    checkOutput("starve_cpu_before_lcd", cpuBefore, 4);
    checkOutput("starve_lcd_ack_cycle", lcdAt, 24);
    checkOutput("starve_cpu_total", cpuAcks, 11);
`else
    checkOutput("starve_lcd_never", lcdAt, 32'hFFFF_FFFF);
    checkOutput("starve_cpu_total", cpuAcks, 12);
`endif

    // Reset during ACC cycle 1 of a write
    applyStimulus(1'b1, 1'b1, 19'h00020, 8'h77, 1'b0, 19'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_we_low_before_rst", ramWeN, 0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_strobes", {ramCeN, ramOeN, ramWeN}, 3'b111);
    checkOutput("mid_rst_bus", {ramA, ramDi}, 0);
    anyAck = 0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if (cpuAck || lcdAck) anyAck++;
    end
    checkOutput("mid_rst_no_ack", anyAck, 0);
    checkOutput("mid_rst_mem_untouched", mem[19'h00020], 8'h00);
    reset = 1'b0;
    ackAt = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (cpuAck && ackAt < 0) begin ackAt = i; cpuReq = 1'b0; end
    end
    checkOutput("mid_rst_reserve_ack", ackAt, 4);
    checkOutput("mid_rst_reserve_mem", mem[19'h00020], 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/z88_sram_arb.md
# z88_sram_arb

Two-port arbiter and cycle sequencer for the Z88 internal SRAM (slot 0). It shares the single asynchronous SRAM between the CPU path (Blink-decoded `ma`/`cdo`) and the LCD refresh fetcher. It serialises accesses into fixed-length SRAM cycles and drives `ram_a`, `ram_di`, `ram_ce_n`, `ram_oe_n` and `ram_we_n`. It sits between the Blink glue and the external RAM pins at the top level.

## Interface
- `ACCESS_CYC`, 3: SRAM strobe cycles per access; minimum 3.
- `STARVE_MAX`, 4: consecutive CPU grants tolerated while `lcd_req` is pending (guard build only).
- `clk` in 1: master clock (`mck`). Single clock domain; the block has one clock.
- `reset` in 1: reset is asynchronous and active-high.
- `cpu_req` in 1: CPU access request; held with address and data stable until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 19: CPU byte address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data; valid when `cpu_ack` = 1 and held until the next CPU read completes.
- `cpu_ack` out 1: one-cycle completion pulse.
- `lcd_req` in 1: LCD fetch request (read only).
- `lcd_addr` in 19: LCD fetch address.
- `lcd_rdata` out 8: fetched byte; held like `cpu_rdata`.
- `lcd_ack` out 1: one-cycle completion pulse.
- `ram_a` out 19: SRAM address.
- `ram_di` out 8: data driven to the SRAM.
- `ram_do` in 8: data returned by the SRAM.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n` out 1 each: SRAM strobes, active low.

## Operation
- States: IDLE, ACC, DONE.
- **IDLE**
  - With no request pending, the state stays IDLE.
  - On a request, the winner is chosen, its address, write data and direction are latched, and the block goes to ACC with the counter set to 0.
  - Priority is CPU first, then LCD, except as modified by the starvation guard (see Configuration).
- **ACC** lasts exactly `ACCESS_CYC` cycles, counted 0..`ACCESS_CYC`-1.
  - `ram_ce_n` is 0 in every ACC cycle.
  - Read: `ram_oe_n` is 0 in every ACC cycle. `ram_do` is captured into the winner's rdata register at the clock edge that ends the last ACC cycle.
  - Write: `ram_oe_n` stays 1. `ram_we_n` is 0 in ACC cycles 1..`ACCESS_CYC`-2, giving one cycle of address/data setup and one cycle of hold. `ram_di` = latched write data for the whole ACC period.
- **DONE** lasts one cycle.
  - All strobes are 1 (bus turnaround).
  - The winner's ack is 1.
  - Next state is IDLE.
- Requester rule: deassert req in the cycle after ack. A req that is still high when the block returns to IDLE counts as a new request.
- A request arriving during ACC or DONE waits; the req must stay held.
- `ram_a` and `ram_di` keep their last values in IDLE and DONE. Only the strobes qualify them.
- Reset, including mid-access, forces:
  - state = IDLE and counters = 0;
  - all strobes = 1;
  - `ram_a` = 0, `ram_di` = 0;
  - both acks = 0 and both rdata registers = 0.
  - An interrupted access is simply dropped; no ack is issued.

## Timing
- A request sampled in IDLE at edge N gives:
  - ACC during cycles N+1..N+`ACCESS_CYC`;
  - ack (DONE) at cycle N+`ACCESS_CYC`+1;
  - IDLE at cycle N+`ACCESS_CYC`+2.
- Latency from req to ack is `ACCESS_CYC`+1 cycles. Peak throughput is one access per `ACCESS_CYC`+2 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `Z88_SRAM_ARB_STARVE_GUARD_EN` defined:
  - A starvation counter (0..`STARVE_MAX`) increments on each CPU grant made while `lcd_req` = 1.
  - When the counter equals `STARVE_MAX`, the next IDLE arbitration with `lcd_req` = 1 grants LCD, even if `cpu_req` = 1.
  - The counter clears on any LCD grant, or in any cycle with `lcd_req` = 0.
- Macro undefined: strict CPU priority and no counter logic. LCD can starve indefinitely.

## Structure
- `z88_pkg`:
  - `Z88_ADDR_W` = 19 and `Z88_DATA_W` = 8;
  - the arbiter state enum (IDLE/ACC/DONE);
  - a grant-owner enum (CPU/LCD).
- Single module `z88_sram_arb`. The starvation guard is a small inline counter under the macro; no sub-module.

## Test plan
- **Lone CPU read**, `ACCESS_CYC`=3, addr 0x12345, SRAM model returns 0xA5: `ram_ce_n`/`ram_oe_n` low for exactly 3 cycles; `cpu_ack` pulses 4 cycles after req; `cpu_rdata` = 0xA5.
- **CPU write** 0x3C to 0x00010: `ram_we_n` low only in ACC cycle 1, with `ram_a` = 0x00010 and `ram_di` = 0x3C stable from ACC cycle 0 through ACC cycle 2; SRAM model holds 0x3C afterwards.
- **Simultaneous `cpu_req` and `lcd_req` in IDLE**: CPU is served first; LCD is served immediately after; `lcd_ack` arrives 5 cycles after `cpu_ack`.
- **Guard build, CPU requesting continuously**, `lcd_req` held, `STARVE_MAX`=4: LCD is granted after exactly 4 CPU grants. Non-guard build: `lcd_ack` never pulses.
- **Reset asserted in ACC cycle 1 of a write**: strobes go to 1 immediately (asynchronous); no ack; the state restarts in IDLE after reset is released, and the held req is then served.
